// File: rtl/systolic_fir_preadd_n.sv
// systolic_fir_preadd_n
//    N-tap systolic FIR with a symmetric preadder (x(n)+p(n) before the
//    multiply), convergent or floor output rounding, optional output
//    saturation and a double-buffered coefficient bank that is swapped
//    atomically on command.
//
// Ports
//    clk_i           filter clock
//    rst_i           asynchronous, active-high reset
//    ce_i            clock enable for datapath, commit and settle counter
//    dat_i           signed sample x(n), NBITS
//    preadd_i        signed sample p(n), NBITS
//    coeff_addr_i    shadow tap index
//    coeff_dat_i     signed coefficient, COEFF_BITS
//    coeff_wr_i      shadow write strobe (honoured regardless of ce_i)
//    coeff_commit_i  copy shadow bank into active bank (needs ce_i)
//    coeff_ack_o     one-cycle pulse on the cycle after an accepted commit
//    ovf_clr_i       clears ovf_o (a coincident saturation wins)
//    dat_o           rounded, saturated output, NBITS+1
//    valid_o         high once the pipeline has fully settled
//    ovf_o           sticky saturation flag
//    p_o             full-precision accumulator aligned with dat_o
//
// Latency from the x(n)/p(n) capture edge to the dat_o/p_o edge is NTAPS+3
// ce-qualified cycles.

module systolic_fir_preadd_n #(
   parameter int    NTAPS      = 5,
   parameter int    NBITS      = 12,
   parameter int    COEFF_BITS = 18,
   parameter int    SHIFT      = 17,
   parameter string ROUND      = "TRUE",
   parameter string SATURATE   = "TRUE",
   localparam int   AW         = (NTAPS > 1) ? $clog2(NTAPS) : 1,
   localparam int   ACCW       = NBITS + 1 + COEFF_BITS + $clog2(NTAPS)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         ce_i,
   input  logic signed [NBITS-1:0]      dat_i,
   input  logic signed [NBITS-1:0]      preadd_i,
   input  logic        [AW-1:0]         coeff_addr_i,
   input  logic signed [COEFF_BITS-1:0] coeff_dat_i,
   input  logic                         coeff_wr_i,
   input  logic                         coeff_commit_i,
   output logic                         coeff_ack_o,
   input  logic                         ovf_clr_i,
   output logic signed [NBITS:0]        dat_o,
   output logic                         valid_o,
   output logic                         ovf_o,
   output logic signed [ACCW-1:0]       p_o
);

   localparam int PREW    = NBITS + 1;
   localparam int PRODW   = PREW + COEFF_BITS;
   localparam int LATENCY = NTAPS + 3;
   localparam int CNTW    = $clog2(LATENCY + 1);
   // Rounded value before clamping: the shifted accumulator plus one bit of
   // headroom for the round-up, widened so the clamp limits always fit.
   localparam int RW      = ACCW - SHIFT + 1;
   localparam int SW      = (RW > NBITS + 2) ? RW : NBITS + 2;
   localparam bit DO_ROUND = (ROUND == "TRUE");
   localparam bit DO_SAT   = (SATURATE == "TRUE");

   localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< NBITS) - 64'sd1);
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   logic signed [COEFF_BITS-1:0] shadow_r [NTAPS];
   logic signed [COEFF_BITS-1:0] active_r [NTAPS];
   // Sample chain: two registers per tap so each sample meets the partial
   // sum travelling one register per tap down the accumulator chain.
   logic signed [PREW-1:0]       dly_r    [2*NTAPS-1];
   logic signed [PRODW-1:0]      prod_r   [NTAPS];
   logic signed [ACCW-1:0]       acc_r    [NTAPS];
   logic signed [SW-1:0]         rnd_r;
   logic signed [ACCW-1:0]       acc_d_r;
   logic signed [NBITS:0]        dat_r;
   logic signed [ACCW-1:0]       p_r;
   logic                         ovf_r;
   logic                         ack_r;
   logic                         valid_r;
   logic        [CNTW-1:0]       cnt_r;

   logic                         commit_s;
   logic        [NTAPS-1:0]      wr_hit_s;
   logic signed [ACCW-1:0]       acc_last_s;
   logic signed [SW-1:0]         rnd_s;
   logic signed [NBITS:0]        dat_s;
   logic                         sat_s;

   assign commit_s   = coeff_commit_i & ce_i;
   assign acc_last_s = acc_r[NTAPS-1];

   // Decode the shadow write address; out-of-range addresses hit no tap.
   always_comb begin
      wr_hit_s = '0;
      for (int k = 0; k < NTAPS; k++) begin
         if (coeff_wr_i && (coeff_addr_i == AW'(k))) begin
            wr_hit_s[k] = 1'b1;
         end else begin
            wr_hit_s[k] = 1'b0;
         end
      end
   end

   // Shadow bank: written on any clock, independent of ce_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NTAPS; k++) shadow_r[k] <= '0;
      end else begin
         for (int k = 0; k < NTAPS; k++) begin
            if (wr_hit_s[k]) shadow_r[k] <= coeff_dat_i;
         end
      end
   end

   // Active bank: whole-bank copy on commit, folding in a same-cycle write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NTAPS; k++) active_r[k] <= '0;
      end else if (commit_s) begin
         for (int k = 0; k < NTAPS; k++) begin
            active_r[k] <= wr_hit_s[k] ? coeff_dat_i : shadow_r[k];
         end
      end
   end

   // Systolic datapath: preadd, sample chain, products, accumulator chain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2*NTAPS-1; i++) dly_r[i] <= '0;
         for (int k = 0; k < NTAPS; k++) begin
            prod_r[k] <= '0;
            acc_r[k]  <= '0;
         end
      end else if (ce_i) begin
         dly_r[0] <= PREW'(dat_i) + PREW'(preadd_i);
         for (int i = 1; i < 2*NTAPS-1; i++) dly_r[i] <= dly_r[i-1];
         for (int k = 0; k < NTAPS; k++) begin
            prod_r[k] <= PRODW'(dly_r[2*k]) * PRODW'(active_r[k]);
         end
         acc_r[0] <= ACCW'(prod_r[0]);
         for (int k = 1; k < NTAPS; k++) acc_r[k] <= acc_r[k-1] + ACCW'(prod_r[k]);
      end
   end

   generate
      if (SHIFT == 0) begin : g_noshift
         assign rnd_s = SW'(acc_last_s);
      end else begin : g_shift
         localparam logic [SHIFT-1:0] HALF_V = SHIFT'(64'd1 << (SHIFT - 1));
         logic signed [RW-1:0] flr_s;
         logic        [SHIFT-1:0] frac_s;
         logic                 up_s;

         // Floor by arithmetic shift, then round half to even on request.
         always_comb begin
            flr_s  = RW'(signed'(acc_last_s[ACCW-1:SHIFT]));
            frac_s = acc_last_s[SHIFT-1:0];
            up_s   = 1'b0;
            if (DO_ROUND) begin
               if (frac_s > HALF_V) begin
                  up_s = 1'b1;
               end else if (frac_s == HALF_V) begin
                  up_s = flr_s[0];
               end else begin
                  up_s = 1'b0;
               end
            end else begin
               up_s = 1'b0;
            end
            if (up_s) begin
               rnd_s = SW'(flr_s) + SW'(2'sd1);
            end else begin
               rnd_s = SW'(flr_s);
            end
         end
      end
   endgenerate

   // Clamp to the NBITS+1 signed range, or wrap by dropping MSBs.
   always_comb begin
      dat_s = rnd_r[NBITS:0];
      sat_s = 1'b0;
      if (DO_SAT && (rnd_r > MAX_V)) begin
         dat_s = MAX_V[NBITS:0];
         sat_s = 1'b1;
      end else if (DO_SAT && (rnd_r < MIN_V)) begin
         dat_s = MIN_V[NBITS:0];
         sat_s = 1'b1;
      end else begin
         dat_s = rnd_r[NBITS:0];
         sat_s = 1'b0;
      end
   end

   // Rounding and output stages; p_o is delayed to line up with dat_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rnd_r   <= '0;
         acc_d_r <= '0;
         dat_r   <= '0;
         p_r     <= '0;
      end else if (ce_i) begin
         rnd_r   <= rnd_s;
         acc_d_r <= acc_last_s;
         dat_r   <= dat_s;
         p_r     <= acc_d_r;
      end
   end

   // Sticky overflow: a set on the same cycle as a clear wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= (ce_i & sat_s) | (ovf_r & ~ovf_clr_i);
      end
   end

   // Commit acknowledge, one cycle after acceptance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_r <= 1'b0;
      end else begin
         ack_r <= commit_s;
      end
   end

   // Settle counter masks pipeline fill after reset and after every commit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r   <= CNTW'(LATENCY);
         valid_r <= 1'b0;
      end else if (commit_s) begin
         cnt_r   <= CNTW'(LATENCY);
         valid_r <= 1'b0;
      end else if (ce_i && (cnt_r != '0)) begin
         cnt_r   <= cnt_r - CNTW'(1);
         valid_r <= (cnt_r == CNTW'(1));
      end
   end

   assign dat_o       = dat_r;
   assign p_o         = p_r;
   assign ovf_o       = ovf_r;
   assign coeff_ack_o = ack_r;
   assign valid_o     = valid_r;

endmodule

// File: tb/tb_systolic_fir_preadd_n.sv
// Directed self-checking bench for systolic_fir_preadd_n (NTAPS=5,
// NBITS=12). A second instance with ROUND="FALSE" shares all inputs so the
// floor-rounding behaviour is compared against the same stimulus.

module tb_systolic_fir_preadd_n;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               ce_i;
   logic signed [11:0] dat_i;
   logic signed [11:0] preadd_i;
   logic        [2:0]  coeff_addr_i;
   logic signed [17:0] coeff_dat_i;
   logic               coeff_wr_i;
   logic               coeff_commit_i;
   logic               ovf_clr_i;

   logic signed [12:0] dat_a,  dat_b;
   logic               valid_a, valid_b, ovf_a, ovf_b, ack_a, ack_b;
   logic signed [33:0] p_a, p_b;

   int n_pass  = 0;
   int n_total = 0;

   logic signed [11:0] xs [32];
   logic signed [11:0] ps [32];
   logic signed [12:0] cap_a [32];
   logic signed [12:0] cap_b [32];
   logic signed [33:0] cap_p [32];
   logic signed [17:0] bank [5];

   always #5 clk_i = ~clk_i;

   systolic_fir_preadd_n dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .dat_i(dat_i), .preadd_i(preadd_i),
      .coeff_addr_i(coeff_addr_i), .coeff_dat_i(coeff_dat_i), .coeff_wr_i(coeff_wr_i),
      .coeff_commit_i(coeff_commit_i), .coeff_ack_o(ack_a), .ovf_clr_i(ovf_clr_i),
      .dat_o(dat_a), .valid_o(valid_a), .ovf_o(ovf_a), .p_o(p_a));

   systolic_fir_preadd_n #(.ROUND("FALSE")) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .dat_i(dat_i), .preadd_i(preadd_i),
      .coeff_addr_i(coeff_addr_i), .coeff_dat_i(coeff_dat_i), .coeff_wr_i(coeff_wr_i),
      .coeff_commit_i(coeff_commit_i), .coeff_ack_o(ack_b), .ovf_clr_i(ovf_clr_i),
      .dat_o(dat_b), .valid_o(valid_b), .ovf_o(ovf_b), .p_o(p_b));

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill_in(input logic signed [11:0] xv, input logic signed [11:0] pv, input int n);
      for (int i = 0; i < 32; i++) begin
         xs[i] = (i < n) ? xv : 12'sd0;
         ps[i] = (i < n) ? pv : 12'sd0;
      end
   endtask

   // Streams nce ce-qualified samples; cap_*[q] is the output after sample q.
   task automatic stream(input int nce, input bit toggle, input bit wr_shadow);
      int q;
      int cyc;
      q = 0;
      cyc = 0;
      while (q < nce) begin
         ce_i     = toggle ? cyc[0] : 1'b1;
         dat_i    = xs[q];
         preadd_i = ps[q];
         if (wr_shadow && ce_i) begin
            coeff_wr_i   = 1'b1;
            coeff_addr_i = 3'(q % 5);
            coeff_dat_i  = bank[q % 5];
         end else begin
            coeff_wr_i = 1'b0;
         end
         tick();
         if (ce_i) begin
            cap_a[q] = dat_a;
            cap_b[q] = dat_b;
            cap_p[q] = p_a;
            q++;
         end
         cyc++;
      end
      ce_i = 1'b1; coeff_wr_i = 1'b0; dat_i = 12'sd0; preadd_i = 12'sd0;
   endtask

   task automatic load_bank();
      for (int k = 0; k < 5; k++) begin
         coeff_wr_i = 1'b1; coeff_addr_i = 3'(k); coeff_dat_i = bank[k];
         tick();
      end
      coeff_wr_i = 1'b0;
   endtask

   // Commit (optionally with a same-cycle write to tap 0) and count cycles
   // from the commit edge until valid_o rises again.
   task automatic do_commit(input bit wr, input logic signed [17:0] wdat,
                            output logic v0, output logic a1, output logic a2, output int n);
      coeff_commit_i = 1'b1; coeff_wr_i = wr; coeff_addr_i = 3'd0; coeff_dat_i = wdat;
      tick();
      v0 = valid_a; a1 = ack_a;
      coeff_commit_i = 1'b0; coeff_wr_i = 1'b0;
      tick();
      a2 = ack_a;
      n = 1;
      while (!valid_a && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; ce_i = 1'b1; dat_i = 12'sd0; preadd_i = 12'sd0;
      coeff_addr_i = 3'd0; coeff_dat_i = 18'sd0; coeff_wr_i = 1'b0;
      coeff_commit_i = 1'b0; ovf_clr_i = 1'b0;
      tick(); tick();
      n_total++; if ({dat_a, valid_a, ovf_a, ack_a} !== 16'h0) $display("FAIL reset_outs got %h exp 0", {dat_a, valid_a, ovf_a, ack_a}); else n_pass++;
      n_total++; if (p_a !== 34'sd0) $display("FAIL reset_p got %0d exp 0", p_a); else n_pass++;
      rst_i = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_total++; if (valid_a !== (i >= 8)) $display("FAIL reset_valid[%0d] got %b exp %b", i, valid_a, (i >= 8)); else n_pass++;
         n_total++; if (dat_a !== 13'sd0) $display("FAIL reset_dat[%0d] got %0d exp 0", i, dat_a); else n_pass++;
      end
   endtask

   task automatic test_impulse();
      int exp_imp [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 128, 256, 512, 256, 128, 0};
      logic v0, a1, a2;
      int n;
      bank = '{18'sd16384, 18'sd32768, 18'sd65536, 18'sd32768, 18'sd16384};
      load_bank();
      do_commit(1'b0, 18'sd0, v0, a1, a2, n);
      n_total++; if ({v0, a1, a2} !== 3'b010) $display("FAIL impulse_ack got v/a1/a2=%b%b%b exp 010", v0, a1, a2); else n_pass++;
      n_total++; if (n !== 8) $display("FAIL impulse_settle got %0d exp 8", n); else n_pass++;
      fill_in(12'sd1024, 12'sd0, 1);
      stream(14, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         n_total++; if (cap_a[i] !== exp_imp[i]) $display("FAIL impulse_a[%0d] got %0d exp %0d", i, cap_a[i], exp_imp[i]); else n_pass++;
         n_total++; if (cap_b[i] !== exp_imp[i]) $display("FAIL impulse_b[%0d] got %0d exp %0d", i, cap_b[i], exp_imp[i]); else n_pass++;
      end
      n_total++; if (cap_p[8] !== 34'sd16777216) $display("FAIL impulse_p got %0d exp 16777216", cap_p[8]); else n_pass++;
   endtask

   task automatic test_rounding();
      int exp_a [6] = '{2, 2, -2, -2, 0, 2};
      int exp_b [6] = '{1, 2, -2, -3, 0, 1};
      logic v0, a1, a2;
      int n;
      bank = '{18'sd65536, 18'sd0, 18'sd0, 18'sd0, 18'sd0};
      load_bank();
      do_commit(1'b0, 18'sd0, v0, a1, a2, n);
      fill_in(12'sd0, 12'sd0, 0);
      xs[0] = 12'sd3; xs[1] = 12'sd5; xs[2] = -12'sd3; xs[3] = -12'sd5; xs[4] = 12'sd1;
      xs[5] = 12'sd1; ps[5] = 12'sd2;
      stream(14, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         n_total++; if (cap_a[i+8] !== exp_a[i]) $display("FAIL round_even[%0d] got %0d exp %0d", i, cap_a[i+8], exp_a[i]); else n_pass++;
         n_total++; if (cap_b[i+8] !== exp_b[i]) $display("FAIL round_floor[%0d] got %0d exp %0d", i, cap_b[i+8], exp_b[i]); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      logic v0, a1, a2;
      int n;
      bank = '{18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071};
      load_bank();
      do_commit(1'b0, 18'sd0, v0, a1, a2, n);
      fill_in(12'sd2047, 12'sd2047, 32);
      stream(14, 1'b0, 1'b0);
      n_total++; if (cap_a[12] !== 13'sd4095) $display("FAIL sat_pos got %0d exp 4095", cap_a[12]); else n_pass++;
      n_total++; if (cap_p[12] !== 34'sd2683023370) $display("FAIL sat_p got %0d exp 2683023370", cap_p[12]); else n_pass++;
      n_total++; if (ovf_a !== 1'b1) $display("FAIL sat_ovf_set got %b exp 1", ovf_a); else n_pass++;
      fill_in(-12'sd2048, -12'sd2048, 32);
      stream(14, 1'b0, 1'b0);
      n_total++; if (cap_a[12] !== -13'sd4096) $display("FAIL sat_neg got %0d exp -4096", cap_a[12]); else n_pass++;
      // Pipeline still full of -2048 samples: clear coincides with a saturation.
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      n_total++; if (ovf_a !== 1'b1) $display("FAIL sat_set_wins got %b exp 1", ovf_a); else n_pass++;
      n_total++; if (dat_a !== -13'sd4096) $display("FAIL sat_hold_neg got %0d exp -4096", dat_a); else n_pass++;
      fill_in(12'sd0, 12'sd0, 0);
      stream(14, 1'b0, 1'b0);
      n_total++; if (ovf_a !== 1'b1) $display("FAIL sat_sticky got %b exp 1", ovf_a); else n_pass++;
      n_total++; if (cap_a[13] !== 13'sd0) $display("FAIL sat_zero got %0d exp 0", cap_a[13]); else n_pass++;
      ce_i = 1'b0; ovf_clr_i = 1'b1;
      tick();
      ce_i = 1'b1; ovf_clr_i = 1'b0;
      n_total++; if (ovf_a !== 1'b0) $display("FAIL sat_clear got %b exp 0", ovf_a); else n_pass++;
   endtask

   task automatic test_shadow_commit();
      logic v0, a1, a2;
      int n;
      bank = '{18'sd16384, 18'sd32768, 18'sd65536, 18'sd32768, 18'sd16384};
      load_bank();
      do_commit(1'b0, 18'sd0, v0, a1, a2, n);
      // Shadow rewritten to {0,0,65536,0,0} while the active bank keeps running.
      bank = '{18'sd0, 18'sd0, 18'sd65536, 18'sd0, 18'sd0};
      fill_in(12'sd1024, 12'sd0, 1);
      stream(14, 1'b0, 1'b1);
      n_total++; if ({cap_a[8], cap_a[10], cap_a[12]} !== {13'sd128, 13'sd512, 13'sd128})
         $display("FAIL shadow_unchanged got %0d,%0d,%0d exp 128,512,128", cap_a[8], cap_a[10], cap_a[12]); else n_pass++;
      do_commit(1'b0, 18'sd0, v0, a1, a2, n);
      n_total++; if ({v0, a1, a2} !== 3'b010) $display("FAIL commit_ack got v/a1/a2=%b%b%b exp 010", v0, a1, a2); else n_pass++;
      n_total++; if (n !== 8) $display("FAIL commit_settle got %0d exp 8", n); else n_pass++;
      stream(14, 1'b0, 1'b0);
      n_total++; if ({cap_a[8], cap_a[10], cap_a[12]} !== {13'sd0, 13'sd512, 13'sd0})
         $display("FAIL commit_new got %0d,%0d,%0d exp 0,512,0", cap_a[8], cap_a[10], cap_a[12]); else n_pass++;
      // Commit, let the counter fall to 3, then commit again with a tap-0 write.
      coeff_commit_i = 1'b1;
      tick();
      coeff_commit_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_total++; if (valid_a !== 1'b0) $display("FAIL recommit_low got %b exp 0", valid_a); else n_pass++;
      do_commit(1'b1, 18'sd65536, v0, a1, a2, n);
      n_total++; if (n !== 8) $display("FAIL recommit_settle got %0d exp 8", n); else n_pass++;
      stream(14, 1'b0, 1'b0);
      n_total++; if ({cap_a[8], cap_a[9], cap_a[10]} !== {13'sd512, 13'sd0, 13'sd512})
         $display("FAIL commit_write got %0d,%0d,%0d exp 512,0,512", cap_a[8], cap_a[9], cap_a[10]); else n_pass++;
   endtask

   task automatic test_ce_toggle();
      ce_i = 1'b0; coeff_commit_i = 1'b1;
      tick();
      ce_i = 1'b1; coeff_commit_i = 1'b0;
      n_total++; if ({ack_a, valid_a} !== 2'b01) $display("FAIL ce_commit got ack/valid=%b%b exp 01", ack_a, valid_a); else n_pass++;
      fill_in(12'sd1024, 12'sd0, 1);
      stream(14, 1'b1, 1'b0);
      n_total++; if ({cap_a[8], cap_a[9], cap_a[10], cap_a[11]} !== {13'sd512, 13'sd0, 13'sd512, 13'sd0})
         $display("FAIL ce_seq got %0d,%0d,%0d,%0d exp 512,0,512,0", cap_a[8], cap_a[9], cap_a[10], cap_a[11]); else n_pass++;
      n_total++; if (cap_p[8] !== 34'sd67108864) $display("FAIL ce_p got %0d exp 67108864", cap_p[8]); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      int n;
      fill_in(12'sd2047, 12'sd2047, 32);
      stream(10, 1'b0, 1'b0);
      dat_i = 12'sd2047; preadd_i = 12'sd2047; coeff_commit_i = 1'b1;
      tick();
      coeff_commit_i = 1'b0;
      n_total++; if ({ack_a, dat_a} !== {1'b1, 13'sd4094}) $display("FAIL pre_reset got ack=%b dat=%0d exp 1,4094", ack_a, dat_a); else n_pass++;
      #2;
      rst_i = 1'b1;
      #1;
      n_total++; if ({dat_a, valid_a, ovf_a, ack_a} !== 16'h0) $display("FAIL async_reset got %h exp 0", {dat_a, valid_a, ovf_a, ack_a}); else n_pass++;
      n_total++; if (p_a !== 34'sd0) $display("FAIL async_reset_p got %0d exp 0", p_a); else n_pass++;
      tick();
      rst_i = 1'b0;
      n = 0;
      while (!valid_a && n < 40) begin
         tick();
         n++;
      end
      n_total++; if (n !== 8) $display("FAIL post_reset_settle got %0d exp 8", n); else n_pass++;
      stream(14, 1'b0, 1'b0);
      n_total++; if ({cap_a[12], cap_p[12]} !== {13'sd0, 34'sd0}) $display("FAIL coeff_cleared got %0d/%0d exp 0/0", cap_a[12], cap_p[12]); else n_pass++;
      n_total++; if (ack_a !== 1'b0) $display("FAIL ack_dropped got %b exp 0", ack_a); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_rounding();
      test_saturation();
      test_shadow_commit();
      test_ce_toggle();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
